gray_seq_gen: RTL and testbench
===============================

GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of the index and of the Gray output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to move from IDLE to ACTIVE.
REQ-005 The block SHALL have port stop, input, 1 bit: request to move from ACTIVE to IDLE.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = step index up, 1 = step index down.
REQ-007 The block SHALL have port load, input, 1 bit: overwrite the index with load_val.
REQ-008 The block SHALL have port load_val, input, DATA_WIDTH bits: binary index to load.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream Gray-to-binary consumer accepts gray_out.
REQ-010 The block SHALL have port gray_out, output, DATA_WIDTH bits: registered Gray code of the current index, (idx ^ (idx >> 1)).
REQ-011 The block SHALL have port out_valid, output, 1 bit: gray_out is offered for transfer.
REQ-012 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking an index wrap-around.

Function
REQ-013 The block SHALL hold an internal DATA_WIDTH-bit binary index idx, and SHALL keep gray_out equal to Gray(idx) at every cycle after reset.
REQ-014 The block SHALL implement a two-state FSM: IDLE with out_valid=0, and ACTIVE with out_valid=1.
REQ-015 In IDLE with start=1 and stop=0, the FSM SHALL enter ACTIVE on the next edge, and out_valid SHALL be 1 from that cycle on.
REQ-016 In ACTIVE with stop=1, the FSM SHALL enter IDLE on the next edge; start SHALL be ignored in ACTIVE.
REQ-017 When start=1 and stop=1 in the same cycle, stop SHALL win: the FSM goes to or stays in IDLE.
REQ-018 A transfer SHALL occur only in a cycle where out_valid=1 and out_ready=1.
REQ-019 On a transfer without load, idx SHALL become idx+1 (dir=0) or idx-1 (dir=1) modulo 2^DATA_WIDTH on the next edge, giving one cycle of latency.
REQ-020 Without a transfer or a load, gray_out SHALL hold its value, and out_valid SHALL change only through the FSM.
REQ-021 A transfer with stop=1 in the same cycle SHALL still count: idx advances and the FSM enters IDLE.
REQ-022 load=1 SHALL set idx to load_val on the next edge in either state, and SHALL override any transfer-driven step in that cycle.
REQ-023 load SHALL NOT change the FSM state; load with start in IDLE SHALL apply both.
REQ-024 wrap SHALL be 1 for exactly one cycle after a transfer-driven step from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-025 wrap SHALL never be asserted because of a load.
REQ-026 Successive gray_out values produced by transfer-driven steps SHALL differ in exactly one bit, including across wrap-around.

Reset
REQ-027 While resetn=0, the block SHALL immediately force idx=0, gray_out=0, out_valid=0, wrap=0, and state IDLE, independent of clk.
REQ-028 The block SHALL NOT update state on the first clk edge at which resetn is already 1.
REQ-029 Reset asserted mid-operation, including during a pending transfer or load, SHALL discard that operation with no partial update.

Verification (DATA_WIDTH=4)
REQ-030 The bench SHALL cover: reset, start pulse, out_ready held 1, dir=0 -> out_valid rises the cycle after start; gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap=1 only the cycle after the 8->0 step.
REQ-031 The bench SHALL cover: ACTIVE, out_ready toggling 1,0,0,1 -> gray_out advances only after the cycles with out_ready=1 and is stable otherwise.
REQ-032 The bench SHALL cover: idx=0 in ACTIVE, dir=1, one transfer -> gray_out=8 (idx=F), wrap pulses once.
REQ-033 The bench SHALL cover: load=1, load_val=5, with a concurrent transfer -> gray_out=7 next cycle, no step applied, wrap=0.
REQ-034 The bench SHALL cover: start and stop asserted together in IDLE -> out_valid stays 0; stop with out_ready=1 in ACTIVE -> one step taken, then out_valid=0.
REQ-035 The bench SHALL cover: resetn pulled low between edges while ACTIVE at gray_out=D -> outputs go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: steps a binary index up or down on each accepted
// transfer, and presents the registered Gray code of that index with a valid/ready handshake.
module gray_seq_gen #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic                  out_valid,
    output logic                  wrap
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    state_t                state;
    state_t                state_nxt;
    logic                  armed;
    logic [DATA_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] idx_nxt;
    logic                  wrap_nxt;
    logic                  xfer;

    function automatic logic [DATA_WIDTH-1:0] to_gray(input logic [DATA_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign xfer      = (state == ACTIVE) && out_ready;
    assign out_valid = (state == ACTIVE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wrap_nxt  = 1'b0;

        // stop has priority over start when both are raised in IDLE
        case (state)
            IDLE:    if (start && !stop) state_nxt = ACTIVE;
            ACTIVE:  if (stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            idx_nxt = load_val;
        end else if (xfer) begin
            if (dir) begin
                idx_nxt  = idx - ONE;
                wrap_nxt = (idx == '0);
            end else begin
                idx_nxt  = idx + ONE;
                wrap_nxt = (idx == ALL_ONES);
            end
        end
    end

    // The first edge after reset release only arms the block, so a reset
    // deasserted close to an edge can never produce a partial update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed    <= 1'b0;
            state    <= IDLE;
            idx      <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            gray_out <= to_gray(idx_nxt);
            wrap     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen at DATA_WIDTH=4 with hand-computed Gray values.
module tb_gray_seq_gen;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] load_val = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] gray_out;
    logic          out_valid;
    logic          wrap;

    int checks = 0;
    int errors = 0;

    // Gray codes of idx 1..15 then 0, as produced by successive up-steps from 0.
    logic [DW-1:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                   4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    gray_seq_gen #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .out_ready (out_ready),
        .gray_out  (gray_out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // reset
        #1 resetn = 1'b0;
        #2;
        chk("rst_gray", 32'(gray_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        tick();
        resetn = 1'b1;

        // first edge after release is ignored even with start asserted
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arm_valid", 32'(out_valid), 32'h0);
        tick();
        start = 1'b0;
        chk("start_valid", 32'(out_valid), 32'h1);
        chk("start_gray", 32'(gray_out), 32'h0);

        // full up sequence with wrap only after 8 -> 0
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("up_gray%0d", i), 32'(gray_out), 32'(up_seq[i]));
            chk($sformatf("up_wrap%0d", i), 32'(wrap), (i == 15) ? 32'h1 : 32'h0);
        end

        // ready pattern 1,0,0,1
        tick();
        chk("rdy1_gray", 32'(gray_out), 32'h1);
        out_ready = 1'b0;
        tick();
        chk("rdy0a_gray", 32'(gray_out), 32'h1);
        tick();
        chk("rdy0b_gray", 32'(gray_out), 32'h1);
        out_ready = 1'b1;
        tick();
        chk("rdy1b_gray", 32'(gray_out), 32'h3);

        // load 0 without transfer, then one down step
        out_ready = 1'b0;
        load = 1'b1;
        load_val = 4'h0;
        tick();
        load = 1'b0;
        chk("ld0_gray", 32'(gray_out), 32'h0);
        chk("ld0_wrap", 32'(wrap), 32'h0);
        dir = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("down_gray", 32'(gray_out), 32'h8);
        chk("down_wrap", 32'(wrap), 32'h1);
        tick();
        chk("down_hold_gray", 32'(gray_out), 32'h8);
        chk("down_wrap_clr", 32'(wrap), 32'h0);

        // load over a transfer that would otherwise wrap F -> 0
        dir = 1'b0;
        out_ready = 1'b1;
        load = 1'b1;
        load_val = 4'h5;
        tick();
        load = 1'b0;
        chk("ldx_gray", 32'(gray_out), 32'h7);
        chk("ldx_wrap", 32'(wrap), 32'h0);
        chk("ldx_valid", 32'(out_valid), 32'h1);

        // stop with a transfer: one step, then IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_gray", 32'(gray_out), 32'h5);
        chk("stop_valid", 32'(out_valid), 32'h0);
        tick();
        chk("idle_hold_gray", 32'(gray_out), 32'h5);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("ss_valid", 32'(out_valid), 32'h0);

        // load with start in IDLE applies both
        out_ready = 1'b0;
        load = 1'b1;
        load_val = 4'hC;
        tick();
        start = 1'b0;
        chk("ldst_valid", 32'(out_valid), 32'h1);
        chk("ldst_gray", 32'(gray_out), 32'hA);

        // reach gray D, then asynchronous reset between edges with a load pending
        load_val = 4'h9;
        tick();
        chk("pre_rst_gray", 32'(gray_out), 32'hD);
        load_val = 4'h3;
        out_ready = 1'b1;
        #3 resetn = 1'b0;
        #1;
        chk("arst_gray", 32'(gray_out), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        tick();
        chk("arst_edge_gray", 32'(gray_out), 32'h0);
        resetn = 1'b1;
        tick();
        chk("rel_arm_gray", 32'(gray_out), 32'h0);
        tick();
        load = 1'b0;
        chk("rel_load_gray", 32'(gray_out), 32'h2);
        chk("rel_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
